// File: rtl/mem_bus_bridge.sv
// MEM-stage bus bridge: runs one req/ack bus transaction per CPU access,
// stalls the pipeline meanwhile, replicates store lanes and extends loads.
module mem_bus_bridge #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   input  logic [3:0]  be,
   input  logic        we,
   input  logic        re,
   input  logic [2:0]  lsel,
   output logic [31:0] rd,
   output logic        stall,
   output logic        err,
   output logic [29:0] dev_addr,
   output logic [31:0] dev_wd,
   output logic [3:0]  dev_be,
   output logic        dev_we,
   output logic        dev_req,
   input  logic        dev_ack,
   input  logic [31:0] dev_rd
);

   localparam int unsigned CW = 8;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    off_q, off_d;
   logic [2:0]    lsel_q, lsel_d;
   logic [29:0]   dev_addr_q, dev_addr_d;
   logic [31:0]   dev_wd_q, dev_wd_d;
   logic [3:0]    dev_be_q, dev_be_d;
   logic          dev_we_q, dev_we_d;
   logic          dev_req_q, dev_req_d;
   logic [31:0]   rd_q, rd_d;
   logic          err_q, err_d;

   logic          req_c;
   logic [31:0]   repl_c;
   logic [31:0]   shift_c;
   logic [7:0]    byte_c;
   logic [15:0]   half_c;
   logic [31:0]   ext_c;

   // A store with no enabled lanes is not an access at all
   assign req_c = we ? (be != 4'b0000) : re;
   assign stall = ((state_q == S_IDLE) && req_c) || (state_q == S_BUS);

   // Store lane replication and load extraction
   always_comb begin
      repl_c  = {4{wd[7:0]}};
      case (be)
         4'b1111:          repl_c = wd;
         4'b0011, 4'b1100: repl_c = {2{wd[15:0]}};
         default:          repl_c = {4{wd[7:0]}};
      endcase

      shift_c = dev_rd >> {off_q, 3'b000};
      byte_c  = shift_c[7:0];
      half_c  = off_q[1] ? dev_rd[31:16] : dev_rd[15:0];
      case (lsel_q)
         3'b001:  ext_c = {16'h0000, half_c};
         3'b010:  ext_c = {{16{half_c[15]}}, half_c};
         3'b011:  ext_c = {24'h000000, byte_c};
         3'b100:  ext_c = {{24{byte_c[7]}}, byte_c};
         default: ext_c = dev_rd;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      off_d      = off_q;
      lsel_d     = lsel_q;
      dev_addr_d = dev_addr_q;
      dev_wd_d   = dev_wd_q;
      dev_be_d   = dev_be_q;
      dev_we_d   = dev_we_q;
      rd_d       = rd_q;
      err_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_c) begin
               state_d    = S_BUS;
               cnt_d      = '0;
               off_d      = addr[1:0];
               lsel_d     = lsel;
               dev_addr_d = addr[31:2];
               dev_we_d   = we;
               dev_be_d   = we ? be : 4'b0000;
               dev_wd_d   = repl_c;
            end
         end
         S_BUS: begin
            if (dev_ack) begin
               state_d = S_DONE;
               if (!dev_we_q) rd_d = ext_c;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               if (!dev_we_q) rd_d = 32'h0;
            end else begin
               cnt_d = CW'(cnt_q + 1'b1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      dev_req_d = (state_d == S_BUS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         off_q      <= '0;
         lsel_q     <= '0;
         dev_addr_q <= '0;
         dev_wd_q   <= '0;
         dev_be_q   <= '0;
         dev_we_q   <= 1'b0;
         dev_req_q  <= 1'b0;
         rd_q       <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         off_q      <= off_d;
         lsel_q     <= lsel_d;
         dev_addr_q <= dev_addr_d;
         dev_wd_q   <= dev_wd_d;
         dev_be_q   <= dev_be_d;
         dev_we_q   <= dev_we_d;
         dev_req_q  <= dev_req_d;
         rd_q       <= rd_d;
         err_q      <= err_d;
      end
   end

   assign rd       = rd_q;
   assign err      = err_q;
   assign dev_addr = dev_addr_q;
   assign dev_wd   = dev_wd_q;
   assign dev_be   = dev_be_q;
   assign dev_we   = dev_we_q;
   assign dev_req  = dev_req_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: one default-timeout instance and one
// with TIMEOUT=4 sharing the CPU-side stimulus.
module tb_mem_bus_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr, wd, dev_rd;
   logic [3:0]  be;
   logic        we, re, dev_ack, ack_t;
   logic [2:0]  lsel;

   logic [31:0] rd, dev_wd, rd_t, dev_wd_t;
   logic        stall, err, dev_we, dev_req;
   logic        stall_t, err_t, dev_we_t, dev_req_t;
   logic [29:0] dev_addr, dev_addr_t;
   logic [3:0]  dev_be, dev_be_t;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_bus_bridge dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wd(wd), .be(be), .we(we),
      .re(re), .lsel(lsel), .rd(rd), .stall(stall), .err(err),
      .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_be(dev_be), .dev_we(dev_we),
      .dev_req(dev_req), .dev_ack(dev_ack), .dev_rd(dev_rd)
   );

   mem_bus_bridge #(.TIMEOUT(4)) dut_t (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wd(wd), .be(be), .we(we),
      .re(re), .lsel(lsel), .rd(rd_t), .stall(stall_t), .err(err_t),
      .dev_addr(dev_addr_t), .dev_wd(dev_wd_t), .dev_be(dev_be_t), .dev_we(dev_we_t),
      .dev_req(dev_req_t), .dev_ack(ack_t), .dev_rd(dev_rd)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle(input int n);
      we = 1'b0; re = 1'b0; dev_ack = 1'b0; ack_t = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic store_once(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, input logic [31:0] exp_wd);
      cyc(); we = 1'b1; re = 1'b0; addr = a; wd = d; be = b; settle();
      check({tag, "_stall_c0"}, 32'(stall), 32'd1);
      cyc(); we = 1'b0; dev_ack = 1'b1; settle();
      check({tag, "_req"}, 32'(dev_req), 32'd1);
      check({tag, "_we"}, 32'(dev_we), 32'd1);
      check({tag, "_addr"}, 32'(dev_addr), 32'(a[31:2]));
      check({tag, "_wd"}, dev_wd, exp_wd);
      check({tag, "_be"}, 32'(dev_be), 32'(b));
      cyc(); dev_ack = 1'b0; settle();
      check({tag, "_stall_done"}, 32'(stall), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_req_done"}, 32'(dev_req), 32'd0);
      idle(8);
   endtask

   task automatic load_once(input string tag, input logic [31:0] a, input logic [2:0] ls,
                            input logic [31:0] rdv, input logic [31:0] exp_rd);
      cyc(); re = 1'b1; we = 1'b0; addr = a; lsel = ls; settle();
      check({tag, "_stall_c0"}, 32'(stall), 32'd1);
      cyc(); re = 1'b0; dev_ack = 1'b1; ack_t = 1'b1; dev_rd = rdv; settle();
      check({tag, "_be"}, 32'(dev_be), 32'd0);
      check({tag, "_we"}, 32'(dev_we), 32'd0);
      cyc(); dev_ack = 1'b0; ack_t = 1'b0; settle();
      check({tag, "_rd"}, rd, exp_rd);
      check({tag, "_rd_t"}, rd_t, exp_rd);
      check({tag, "_stall_done"}, 32'(stall), 32'd0);
      idle(8);
   endtask

   initial begin
      rst_n = 1'b0; addr = '0; wd = '0; be = '0; we = 1'b0; re = 1'b0;
      lsel = '0; dev_ack = 1'b0; ack_t = 1'b0; dev_rd = '0;
      #12;
      check("rst_req", 32'(dev_req), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_rd", rd, 32'd0);
      check("rst_addr", 32'(dev_addr), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      cyc(); rst_n = 1'b1;
      idle(2);

      store_once("wstore", 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
      store_once("bstore", 32'h0000_0002, 32'h0000_00A5, 4'b0100, 32'hA5A5_A5A5);
      store_once("hstore", 32'h0000_0002, 32'h0000_1234, 4'b1100, 32'h1234_1234);

      load_once("lb00",  32'h0000_0000, 3'b100, 32'h80F0_7F81, 32'hFFFF_FF81);
      load_once("lbu00", 32'h0000_0000, 3'b011, 32'h80F0_7F81, 32'h0000_0081);
      load_once("lb01",  32'h0000_0001, 3'b100, 32'h80F0_7F81, 32'h0000_007F);
      load_once("lh10",  32'h0000_0002, 3'b010, 32'h80F0_7F81, 32'hFFFF_80F0);
      load_once("lhu10", 32'h0000_0002, 3'b001, 32'h80F0_7F81, 32'h0000_80F0);

      // Delayed ack in cycle 5 with CPU inputs toggling under the stall
      cyc(); we = 1'b1; addr = 32'h0000_0100; wd = 32'h1122_3344; be = 4'b1111; settle();
      check("dly_stall_c0", 32'(stall), 32'd1);
      for (int c = 1; c <= 5; c++) begin
         cyc(); we = 1'b0; addr = 32'hFFFF_FFF0 ^ 32'(c); wd = ~wd; dev_ack = (c == 5); settle();
         check($sformatf("dly_req_c%0d", c), 32'(dev_req), 32'd1);
         check($sformatf("dly_addr_c%0d", c), 32'(dev_addr), 32'h0000_0040);
         check($sformatf("dly_wd_c%0d", c), dev_wd, 32'h1122_3344);
         check($sformatf("dly_stall_c%0d", c), 32'(stall), 32'd1);
      end
      cyc(); dev_ack = 1'b0; settle();
      check("dly_stall_done", 32'(stall), 32'd0);
      check("dly_req_done", 32'(dev_req), 32'd0);
      check("dly_rd_kept", rd, 32'h0000_80F0);
      idle(8);

      // Timeout on the TIMEOUT=4 instance, then a late ack
      cyc(); re = 1'b1; we = 1'b0; addr = 32'h0; lsel = 3'b000; settle();
      check("to_stall_c0", 32'(stall_t), 32'd1);
      for (int c = 1; c <= 4; c++) begin
         cyc(); re = 1'b0; dev_ack = (c == 1); dev_rd = 32'h5555_5555; settle();
         check($sformatf("to_stall_c%0d", c), 32'(stall_t), 32'd1);
         check($sformatf("to_err_c%0d", c), 32'(err_t), 32'd0);
      end
      cyc(); dev_ack = 1'b0; settle();
      check("to_stall_c5", 32'(stall_t), 32'd0);
      check("to_err_c5", 32'(err_t), 32'd1);
      check("to_rd_c5", rd_t, 32'd0);
      cyc(); ack_t = 1'b1; settle();
      check("late_err_c6", 32'(err_t), 32'd0);
      check("late_req_c6", 32'(dev_req_t), 32'd0);
      check("late_stall_c6", 32'(stall_t), 32'd0);
      cyc(); ack_t = 1'b0; settle();
      check("late_req_c7", 32'(dev_req_t), 32'd0);
      check("late_rd_c7", rd_t, 32'd0);
      idle(8);

      // Ack in the last wait cycle beats the timeout
      cyc(); re = 1'b1; addr = 32'h0; lsel = 3'b000; settle();
      for (int c = 1; c <= 4; c++) begin
         cyc(); re = 1'b0; dev_ack = (c == 1); ack_t = (c == 4); dev_rd = 32'h1234_5678; settle();
      end
      cyc(); dev_ack = 1'b0; ack_t = 1'b0; settle();
      check("last_err", 32'(err_t), 32'd0);
      check("last_rd", rd_t, 32'h1234_5678);
      check("last_stall", 32'(stall_t), 32'd0);
      idle(8);

      // Reset during BUS
      cyc(); re = 1'b1; addr = 32'h0000_0040; lsel = 3'b000; settle();
      cyc(); re = 1'b0; settle();
      check("rbus_req_c1", 32'(dev_req), 32'd1);
      cyc(); rst_n = 1'b0; settle();
      check("rbus_req", 32'(dev_req), 32'd0);
      check("rbus_stall", 32'(stall), 32'd0);
      check("rbus_err", 32'(err), 32'd0);
      check("rbus_req_t", 32'(dev_req_t), 32'd0);
      cyc(); rst_n = 1'b1; settle();
      check("rbus_idle_req", 32'(dev_req), 32'd0);
      idle(2);
      store_once("post_rst", 32'h0000_2008, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

      // Load then we=re=1 store keeps the loaded rd
      load_once("pre_st", 32'h0000_0000, 3'b000, 32'h1234_5678, 32'h1234_5678);
      cyc(); we = 1'b1; re = 1'b1; addr = 32'h0000_0020; wd = 32'hCAFE_F00D; be = 4'b1111;
      lsel = 3'b100; settle();
      check("wr_stall", 32'(stall), 32'd1);
      cyc(); we = 1'b0; re = 1'b0; dev_ack = 1'b1; dev_rd = 32'hFFFF_FFFF; settle();
      check("wr_we", 32'(dev_we), 32'd1);
      check("wr_be", 32'(dev_be), 32'hF);
      check("wr_wd", dev_wd, 32'hCAFE_F00D);
      cyc(); dev_ack = 1'b0; settle();
      check("wr_rd_kept", rd, 32'h1234_5678);
      idle(8);

      // Store with no lanes enabled is not a request
      cyc(); we = 1'b1; be = 4'b0000; settle();
      check("be0_stall", 32'(stall), 32'd0);
      cyc(); settle();
      check("be0_req", 32'(dev_req), 32'd0);
      check("be0_stall2", 32'(stall), 32'd0);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mem_bus_bridge.md
# mem_bus_bridge

Memory-stage bus bridge for the MIPS microsystem. It takes the CPU's MEM-stage access (address, store data, the 4-bit byte-enable from the byte-enable generator, and load type) and runs one request/acknowledge transaction on the system bus shared by data memory and devices. It stalls the pipeline until the bus acknowledges or a timeout expires, replicates store data onto the enabled byte lanes, and returns sign- or zero-extended load data.

## Interface
- TIMEOUT, 16: bus cycles in BUS state without `dev_ack` before the access is aborted (legal range 2..255).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  32  MEM-stage byte address.
- wd  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- be  in  4  byte enables from the byte-enable generator: 1111 word, 0011/1100 half, one-hot byte.
- we  in  1  store request.
- re  in  1  load request.
- lsel  in  3  load type: 000 lw, 001 lhu, 010 lh, 011 lbu, 100 lb; other codes are treated as lw.
- rd  out  32  extended load data; valid in the DONE cycle and held until the next load completes.
- stall  out  1  freeze the pipeline.
- err  out  1  one-cycle pulse in DONE when the access timed out.
- dev_addr  out  30  word address, addr[31:2] as latched.
- dev_wd  out  32  lane-replicated store data.
- dev_be  out  4  latched be; 0000 on loads.
- dev_we  out  1  write strobe; valid while dev_req is high.
- dev_req  out  1  bus request.
- dev_ack  in  1  bus acknowledge; dev_rd is valid in the same cycle.
- dev_rd  in  32  bus read data, word-aligned.

## Operation
- FSM states: IDLE, BUS, DONE.
- **IDLE**
  - A request is `we`, or `re` with `we` low. `we` with `be == 0000` is not a request.
  - When `we` and `re` are both high, the access is a store.
  - On a request, latch addr, be, lsel and the store/load kind, build dev_wd, and go to BUS.
- **BUS**
  - `dev_req = 1`. dev_addr, dev_wd, dev_be and dev_we come from registers only and stay stable for the whole state.
  - On `dev_ack`, capture dev_rd (loads only) and go to DONE.
  - Otherwise increment the wait counter. When it reaches TIMEOUT-1 without an ack, go to DONE with the timeout flag set.
- **DONE**
  - stall is low and the CPU advances.
  - On timeout: err is high and rd is 32'h0 for a load.
  - Always returns to IDLE. Inputs sampled in DONE are ignored.
- **Store replication**
  - be 1111: dev_wd = wd.
  - Half (0011 or 1100): dev_wd = {wd[15:0], wd[15:0]}.
  - Byte: dev_wd = {4{wd[7:0]}}.
- **Load extraction**, using latched addr[1:0]:
  - Byte lane k = addr[1:0] gives dev_rd[8k+7:8k].
  - Half = addr[1] ? dev_rd[31:16] : dev_rd[15:0].
  - Signed types (lh, lb) sign-extend; unsigned types (lhu, lbu) zero-extend. Misalignment is not checked.
- A `dev_ack` outside BUS is ignored.
- The wait counter clears on entry to BUS.

## Timing
- Reset values: state IDLE, `dev_req = 0`, `dev_we = 0`, `dev_be = 0`, dev_addr, dev_wd and rd all 0, `err = 0`, counter 0. Effect is immediate (asynchronous).
- `stall = (state==IDLE && request) || state==BUS`. This is combinational, so it is high in the same cycle the request first appears.
- Request seen in cycle 0:
  - BUS from cycle 1, so dev_req rises at cycle 1.
  - Ack in cycle 1 gives DONE in cycle 2. Minimum 2 stall cycles.
  - Ack in cycle n gives DONE in cycle n+1.
- Timeout: no ack in cycles 1..TIMEOUT gives DONE in cycle TIMEOUT+1. An ack in the last wait cycle wins over the timeout.
- rd is registered and changes only on the BUS-to-DONE edge of a load.
- Back-to-back: a request held after DONE starts a new transaction in the following IDLE cycle. dev_req is low for at least one cycle between transactions.
- Reset asserted during BUS drops dev_req and stall immediately. No err pulse is produced.

## Test plan
- **Word store:** addr 0x0000_1004, wd 0xDEADBEEF, be 1111, we=1, dev_ack in cycle 1 -> dev_addr 0x401, dev_wd 0xDEADBEEF, dev_be 1111, dev_we 1; stall high in cycles 0–1, low in cycle 2; err 0.
- **Byte store lane replication:** addr 0x...2, wd 0x0000_00A5, be 0100 -> dev_wd 0xA5A5A5A5, dev_be 0100. Half store: wd 0x1234, be 1100 -> dev_wd 0x12341234.
- **Load extension:** dev_rd 0x80F0_7F81.
  - lb at addr[1:0]=00 -> rd 0xFFFF_FF81; lbu at 00 -> 0x0000_0081; lb at 01 -> 0x0000_007F.
  - lh at 10 -> 0xFFFF_80F0; lhu at 10 -> 0x0000_80F0.
- **Delayed ack:** ack in cycle 5 -> stall high cycles 0–5, DONE in cycle 6; bus signals stable cycles 1–5 while addr and wd inputs toggle.
- **Timeout and late ack:**
  - TIMEOUT=4 with no ack -> DONE in cycle 5, err pulse in cycle 5 only, rd 0.
  - Ack arriving in cycle 6 is ignored.
- **Reset and corner requests:**
  - rst_n low in cycle 2 of BUS -> dev_req and stall 0 the same cycle; after release, IDLE with a fresh transaction.
  - we=re=1 -> store performed.
  - we=1 with be=0000 -> no dev_req, no stall.
